// File: rtl/soc_fb_fill_pkg.sv
// Shared definitions for the framebuffer rectangle-fill engine: register map,
// CTRL bit positions and the fill state encoding.
package soc_fb_fill_pkg;

  localparam logic [2:0] REG_X0    = 3'd0;
  localparam logic [2:0] REG_Y0    = 3'd1;
  localparam logic [2:0] REG_W     = 3'd2;
  localparam logic [2:0] REG_H     = 3'd3;
  localparam logic [2:0] REG_COLOR = 3'd4;
  localparam logic [2:0] REG_CTRL  = 3'd5;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLR_BIT   = 1;

  // 17 bits so that X0+W and Y0+H never wrap.
  localparam int COORD_W = 17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } fill_state_t;

endpackage

// File: rtl/soc_fb_fill_mask.sv
// Byte-lane enable generator: lane i is set when pixel (word*4 + i) falls
// inside the inclusive span [xs, xe].
module soc_fb_fill_mask
  import soc_fb_fill_pkg::*;
(
  input  logic [COORD_W-1:0] i_word,
  input  logic [COORD_W-1:0] i_xs,
  input  logic [COORD_W-1:0] i_xe,
  output logic [3:0]         o_mask
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [COORD_W+1:0] w_pix;
    assign w_pix     = {i_word, 2'(i)};
    assign o_mask[i] = (w_pix >= {2'b00, i_xs}) && (w_pix <= {2'b00, i_xe});
  end

endmodule

// File: rtl/soc_fb_fill_engine.sv
// Rectangle-fill master for the VGA framebuffer: CPU-programmed bounds and
// colour, clipped at start, written one 32-bit word (4 pixels) at a time.
module soc_fb_fill_engine
  import soc_fb_fill_pkg::*;
#(
  parameter int FB_WIDTH      = 640,
  parameter int FB_HEIGHT     = 480,
  parameter int FB_ADDR_WIDTH = 18,
  parameter int FB_BASE_WORD  = 0
)(
  input  logic                     clk,
  input  logic                     res,
  input  logic                     cfg_we,
  input  logic [2:0]               cfg_addr,
  input  logic [31:0]              cfg_wdata,
  output logic [31:0]              cfg_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_req,
  output logic [FB_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_wmask,
  input  logic                     mem_ack,
  output fill_state_t              dbg_state
);

  localparam logic [COORD_W-1:0]       C_FBW    = COORD_W'(FB_WIDTH);
  localparam logic [COORD_W-1:0]       C_FBH    = COORD_W'(FB_HEIGHT);
  localparam logic [COORD_W-1:0]       C_ONE    = COORD_W'(1);
  localparam logic [FB_ADDR_WIDTH-1:0] C_STRIDE = FB_ADDR_WIDTH'(FB_WIDTH / 4);
  localparam logic [FB_ADDR_WIDTH-1:0] C_BASE   = FB_ADDR_WIDTH'(FB_BASE_WORD);
  localparam logic [FB_ADDR_WIDTH-1:0] C_AONE   = FB_ADDR_WIDTH'(1);

  logic [15:0]              r_x0, r_y0, r_w, r_h;
  logic [7:0]               r_color;
  fill_state_t              r_state;
  logic                     r_busy, r_done, r_req;
  logic [FB_ADDR_WIDTH-1:0] r_addr, r_row_addr;
  logic [31:0]              r_wdata;
  logic [3:0]               r_wmask;
  logic [COORD_W-1:0]       r_xs, r_xe, r_ye, r_y, r_word, r_word_end;

  logic                     w_ctrl_wr, w_start, w_clear, w_empty;
  logic [COORD_W-1:0]       w_x0e, w_y0e, w_xsum, w_ysum, w_xe, w_ye;
  logic [FB_ADDR_WIDTH-1:0] w_first_row;
  logic [COORD_W-1:0]       w_mask_word;
  logic [3:0]               w_mask;
  logic                     w_unused_wdata;

  assign w_ctrl_wr = cfg_we && (cfg_addr == REG_CTRL);
  assign w_start   = w_ctrl_wr && cfg_wdata[CTRL_START_BIT] && !r_busy;
  assign w_clear   = w_ctrl_wr && cfg_wdata[CTRL_CLR_BIT];
  assign w_unused_wdata = ^cfg_wdata[31:16];

  assign w_x0e  = {1'b0, r_x0};
  assign w_y0e  = {1'b0, r_y0};
  assign w_xsum = w_x0e + {1'b0, r_w};
  assign w_ysum = w_y0e + {1'b0, r_h};
  assign w_xe   = ((w_xsum > C_FBW) ? C_FBW : w_xsum) - C_ONE;
  assign w_ye   = ((w_ysum > C_FBH) ? C_FBH : w_ysum) - C_ONE;
  assign w_empty = (r_w == 16'd0) || (r_h == 16'd0) ||
                   (w_x0e >= C_FBW) || (w_y0e >= C_FBH);

  // Constant-coefficient product for the first row only; later rows step
  // the accumulator by one stride.
  assign w_first_row = C_BASE + FB_ADDR_WIDTH'(32'(r_y0) * 32'(FB_WIDTH / 4))
                       + FB_ADDR_WIDTH'(r_x0[15:2]);

  // Mask is registered alongside the address, so look up the word about to be presented.
  assign w_mask_word = (r_state == SETUP) ? (r_xs >> 2) : (r_word + C_ONE);

  soc_fb_fill_mask u_mask (
    .i_word (w_mask_word),
    .i_xs   (r_xs),
    .i_xe   (r_xe),
    .o_mask (w_mask)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_color <= '0;
    end else if (cfg_we && !r_busy) begin
      case (cfg_addr)
        REG_X0:    r_x0    <= cfg_wdata[15:0];
        REG_Y0:    r_y0    <= cfg_wdata[15:0];
        REG_W:     r_w     <= cfg_wdata[15:0];
        REG_H:     r_h     <= cfg_wdata[15:0];
        REG_COLOR: r_color <= cfg_wdata[7:0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_row_addr <= '0;
      r_xs       <= '0;
      r_xe       <= '0;
      r_ye       <= '0;
      r_y        <= '0;
      r_word     <= '0;
      r_word_end <= '0;
    end else begin
      if (w_clear) r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_xs       <= w_x0e;
            r_xe       <= w_xe;
            r_ye       <= w_ye;
            r_y        <= w_y0e;
            r_word_end <= w_xe >> 2;
            r_row_addr <= w_first_row;
            r_state    <= w_empty ? FINISH : SETUP;
          end
        end
        SETUP: begin
          r_req   <= 1'b1;
          r_addr  <= r_row_addr;
          r_wdata <= {4{r_color}};
          r_wmask <= w_mask;
          r_word  <= r_xs >> 2;
          r_state <= WRITE;
        end
        WRITE: begin
          if (mem_ack) begin
            if (r_word != r_word_end) begin
              r_word  <= r_word + C_ONE;
              r_addr  <= r_addr + C_AONE;
              r_wmask <= w_mask;
            end else begin
              r_req <= 1'b0;
              if (r_y != r_ye) begin
                r_y        <= r_y + C_ONE;
                r_row_addr <= r_row_addr + C_STRIDE;
                r_state    <= SETUP;
              end else begin
                r_state <= FINISH;
              end
            end
          end
        end
        FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      REG_X0:    cfg_rdata = {16'b0, r_x0};
      REG_Y0:    cfg_rdata = {16'b0, r_y0};
      REG_W:     cfg_rdata = {16'b0, r_w};
      REG_H:     cfg_rdata = {16'b0, r_h};
      REG_COLOR: cfg_rdata = {24'b0, r_color};
      REG_CTRL:  cfg_rdata = {30'b0, r_done, r_busy};
      default:   cfg_rdata = '0;
    endcase
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_req   = r_req;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_soc_fb_fill_engine.sv
// Bench for soc_fb_fill_engine: table of fills checked through a write
// scoreboard, plus hand-written timing, backpressure, busy and reset sequences.
module tb_soc_fb_fill_engine;
  import soc_fb_fill_pkg::*;

  localparam int FBW  = 640;
  localparam int FBH  = 480;
  localparam int AW   = 18;
  localparam int SB_W = AW + 32 + 4;

  logic          clk;
  logic          res;
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [31:0]   cfg_wdata;
  logic [31:0]   cfg_rdata;
  logic          busy, done, mem_req, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  fill_state_t   dbg_state;

  soc_fb_fill_engine #(
    .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .FB_ADDR_WIDTH(AW), .FB_BASE_WORD(0)
  ) dut (
    .clk(clk), .res(res), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .busy(busy), .done(done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_wr  = 0;
  int ack_mode = 0;  // 0: always ack, 1: random, 2: held low
  logic [SB_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ack driver
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ack_mode)
        0:       mem_ack = 1'b1;
        1:       mem_ack = 1'($urandom_range(0, 1));
        default: mem_ack = 1'b0;
      endcase
    end
  end

  // scoreboard: every accepted write is popped against the model
  always @(negedge clk) begin
    if (res === 1'b1 && mem_req === 1'b1 && mem_ack === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d mask %b, required no write", mem_addr, mem_wmask);
      end else begin
        check("write", 64'({mem_addr, mem_wdata, mem_wmask}), 64'(exp_q.pop_front()));
      end
    end
  end

  // reference model: pixel-by-pixel lane selection per word
  task automatic push_fill(input int x0, input int y0, input int w, input int h, input logic [7:0] c);
    int xe, ye;
    if (w == 0 || h == 0 || x0 >= FBW || y0 >= FBH) return;
    xe = (((x0 + w) < FBW) ? (x0 + w) : FBW) - 1;
    ye = (((y0 + h) < FBH) ? (y0 + h) : FBH) - 1;
    for (int y = y0; y <= ye; y++) begin
      for (int k = x0 / 4; k <= xe / 4; k++) begin
        logic [3:0] m;
        m = 4'b0000;
        for (int i = 0; i < 4; i++)
          if ((k * 4 + i) >= x0 && (k * 4 + i) <= xe) m[i] = 1'b1;
        exp_q.push_back({AW'(y * (FBW / 4) + k), {4{c}}, m});
      end
    end
  endtask

  // drivers
  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic program_rect(input int x0, input int y0, input int w, input int h, input logic [7:0] c);
    cfg_write(REG_X0, 32'(x0));
    cfg_write(REG_Y0, 32'(y0));
    cfg_write(REG_W, 32'(w));
    cfg_write(REG_H, 32'(h));
    cfg_write(REG_COLOR, {24'b0, c});
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    cfg_addr = a;
    #1;
    check(name, 64'(cfg_rdata), 64'(exp));
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_timeout"}, 64'(cyc < 5000), 64'd1);
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_q_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    int         x0, y0, w, h;
    logic [7:0] color;
    int         ack;
    int         exp_writes;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int wr0, cyc;
    string nm;

    vecs[0]  = '{1, 0, 6, 1, 8'hAB, 0, 2};
    vecs[1]  = '{4, 2, 4, 2, 8'h3C, 0, 2};
    vecs[2]  = '{638, 479, 10, 5, 8'h55, 0, 1};
    vecs[3]  = '{0, 0, 0, 3, 8'h11, 0, 0};
    vecs[4]  = '{10, 10, 5, 0, 8'h22, 0, 0};
    vecs[5]  = '{640, 0, 4, 1, 8'h33, 0, 0};
    vecs[6]  = '{0, 480, 4, 1, 8'h44, 0, 0};
    vecs[7]  = '{3, 5, 9, 3, 8'hC7, 1, 9};
    vecs[8]  = '{0, 0, 640, 1, 8'h0F, 1, 160};
    vecs[9]  = '{65535, 7, 3, 3, 8'h66, 0, 0};
    vecs[10] = '{636, 0, 65535, 2, 8'h81, 1, 2};
    vecs[11] = '{2, 1, 1, 1, 8'hE4, 0, 1};
    vecs[12] = '{5, 470, 20, 40, 8'h5A, 1, 60};
    vecs[13] = '{0, 0, 4, 1, 8'hF0, 0, 1};

    res = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_wmask", 64'(mem_wmask), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    res = 1'b1;
    @(negedge clk);
    read_check("rst_x0", REG_X0, 32'd0);
    read_check("rst_color", REG_COLOR, 32'd0);

    // first-request latency and exact lane masks
    program_rect(1, 0, 6, 1, 8'hAB);
    push_fill(1, 0, 6, 1, 8'hAB);
    cfg_write(REG_CTRL, 32'd1);
    @(negedge clk);
    check("a_busy_n1", 64'(busy), 64'd1);
    check("a_req_n1", 64'(mem_req), 64'd0);
    @(negedge clk);
    check("a_req_n2", 64'(mem_req), 64'd1);
    check("a_addr0", 64'(mem_addr), 64'd0);
    check("a_data0", 64'(mem_wdata), 64'hABABABAB);
    check("a_mask0", 64'(mem_wmask), 64'b1110);
    @(negedge clk);
    check("a_addr1", 64'(mem_addr), 64'd1);
    check("a_mask1", 64'(mem_wmask), 64'b0111);
    @(negedge clk);
    check("a_req_fin", 64'(mem_req), 64'd0);
    @(negedge clk);
    check("a_done", 64'(done), 64'd1);
    check("a_busy", 64'(busy), 64'd0);
    check("a_q_empty", 64'(exp_q.size()), 64'd0);

    // SETUP gap between rows
    program_rect(4, 2, 4, 2, 8'h3C);
    push_fill(4, 2, 4, 2, 8'h3C);
    cfg_write(REG_CTRL, 32'd1);
    @(negedge clk); check("b_req_n1", 64'(mem_req), 64'd0);
    @(negedge clk); check("b_req_n2", 64'(mem_req), 64'd1);
    check("b_addr_r0", 64'(mem_addr), 64'd321);
    @(negedge clk); check("b_gap", 64'(mem_req), 64'd0);
    @(negedge clk); check("b_req_n4", 64'(mem_req), 64'd1);
    check("b_addr_r1", 64'(mem_addr), 64'd481);
    @(negedge clk); check("b_req_n5", 64'(mem_req), 64'd0);
    @(negedge clk); check("b_done_n6", 64'(done), 64'd1);

    // backpressure: request held stable while ack stays low
    program_rect(4, 2, 4, 2, 8'h3C);
    push_fill(4, 2, 4, 2, 8'h3C);
    ack_mode = 2;
    wr0 = n_wr;
    cfg_write(REG_CTRL, 32'd1);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("c_hold_req", 64'(mem_req), 64'd1);
      check("c_hold_addr", 64'(mem_addr), 64'd321);
      check("c_hold_data", 64'(mem_wdata), 64'h3C3C3C3C);
      check("c_hold_mask", 64'(mem_wmask), 64'hF);
      check("c_hold_cnt", 64'(n_wr - wr0), 64'd0);
      @(negedge clk);
    end
    ack_mode = 0;
    wait_idle("c");
    check("c_writes", 64'(n_wr - wr0), 64'd2);

    // table-driven fills
    for (int i = 0; i < 14; i++) begin
      nm = $sformatf("vec%0d", i);
      ack_mode = vecs[i].ack;
      program_rect(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].color);
      push_fill(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].color);
      wr0 = n_wr;
      cfg_write(REG_CTRL, 32'd1);
      wait_idle(nm);
      check({nm, "_writes"}, 64'(n_wr - wr0), 64'(vecs[i].exp_writes));
      ack_mode = 0;
    end

    // register writes and start while busy are ignored
    ack_mode = 1;
    program_rect(0, 10, 16, 3, 8'h5A);
    push_fill(0, 10, 16, 3, 8'h5A);
    wr0 = n_wr;
    cfg_write(REG_CTRL, 32'd1);
    cfg_write(REG_X0, 32'd100);
    cfg_write(REG_W, 32'd1);
    cfg_write(REG_COLOR, 32'hFF);
    cfg_write(REG_CTRL, 32'd1);
    wait_idle("d");
    check("d_writes", 64'(n_wr - wr0), 64'd12);
    read_check("d_x0", REG_X0, 32'd0);
    read_check("d_w", REG_W, 32'd16);
    read_check("d_color", REG_COLOR, 32'h5A);
    read_check("d_ctrl", REG_CTRL, 32'h2);
    ack_mode = 0;

    // clear done, empty-rectangle timing, clear+start together
    cfg_write(REG_CTRL, 32'd2);
    check("e_cleared", 64'(done), 64'd0);
    program_rect(3, 3, 0, 5, 8'h12);
    cfg_write(REG_CTRL, 32'd1);
    @(negedge clk);
    check("e_busy_n1", 64'(busy), 64'd1);
    check("e_done_n1", 64'(done), 64'd0);
    @(negedge clk);
    check("e_busy_n2", 64'(busy), 64'd0);
    check("e_done_n2", 64'(done), 64'd1);
    program_rect(8, 0, 4, 1, 8'h99);
    push_fill(8, 0, 4, 1, 8'h99);
    wr0 = n_wr;
    cfg_write(REG_CTRL, 32'd3);
    check("e_clr_start_done", 64'(done), 64'd0);
    check("e_clr_start_busy", 64'(busy), 64'd1);
    wait_idle("e");
    check("e_writes", 64'(n_wr - wr0), 64'd1);
    cfg_write(3'd6, 32'hFFFFFFFF);
    read_check("e_reg6", 3'd6, 32'd0);
    read_check("e_reg7", 3'd7, 32'd0);

    // reset during the second row of a four-row fill
    program_rect(0, 0, 8, 4, 8'h77);
    push_fill(0, 0, 8, 4, 8'h77);
    cfg_write(REG_CTRL, 32'd1);
    cyc = 0;
    while (!(mem_req === 1'b1 && mem_addr == AW'(160)) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("f_reach_row2", 64'(cyc < 200), 64'd1);
    #1 res = 1'b0;
    #1;
    check("f_req_drop", 64'(mem_req), 64'd0);
    check("f_busy", 64'(busy), 64'd0);
    check("f_done", 64'(done), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    res = 1'b1;
    read_check("f_x0_rst", REG_X0, 32'd0);
    program_rect(4, 2, 4, 2, 8'h3C);
    push_fill(4, 2, 4, 2, 8'h3C);
    wr0 = n_wr;
    cfg_write(REG_CTRL, 32'd1);
    wait_idle("f_after");
    check("f_after_writes", 64'(n_wr - wr0), 64'd2);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/soc_fb_fill_engine.md
Name: soc_fb_fill_engine

Overview:
Hardware rectangle-fill accelerator that writes solid-colour rectangles into the VGA framebuffer.
- It sits directly upstream of soc_video_controller and feeds its framebuffer memory bus. The SoC interconnect arbitrates this block as a second master alongside the CPU.
- The CPU programs the block through a small register port, starts a fill and polls busy/done.
- Pixels are 8 bit, packed 4 per 32-bit word, little-endian: pixel 4k+i is in byte lane i of word k.

Parameters:
- FB_WIDTH, 640, pixels per line (line stride); must be a multiple of 4.
- FB_HEIGHT, 480, number of lines.
- FB_ADDR_WIDTH, 18, width of the framebuffer word address.
- FB_BASE_WORD, 0, word address of pixel (0,0).

Ports:
- clk  in  1  single clock (main_clk domain).
- res  in  1  asynchronous, active-low reset.
- cfg_we  in  1  register write strobe.
- cfg_addr  in  3  register index.
- cfg_wdata  in  32  register write data.
- cfg_rdata  out  32  register read data, combinational from cfg_addr.
- busy  out  1  fill in progress.
- done  out  1  sticky completion flag.
- mem_req  out  1  write request.
- mem_addr  out  FB_ADDR_WIDTH  word address.
- mem_wdata  out  32  write data.
- mem_wmask  out  4  byte-lane enables.
- mem_ack  in  1  write accepted this cycle.

Behaviour:
- Registers:
  - 0 X0[15:0], 1 Y0[15:0], 2 W[15:0], 3 H[15:0], 4 COLOR[7:0].
  - 5 CTRL: write bit0=start, bit1=clear done. Read returns {30'b0, done, busy}.
  - Indices 6-7: writes are ignored, reads return 0.
  - Writes to registers 0-4 while busy are ignored.
- Reset (res low, asynchronous): all registers 0, state IDLE, busy=0, done=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_wmask=0.
  - Reset mid-fill drops mem_req immediately. The partial fill stays in memory.
- Clipping is computed at start:
  - xe = min(X0+W, FB_WIDTH) - 1; ye = min(Y0+H, FB_HEIGHT) - 1.
  - Empty if W==0, H==0, X0>=FB_WIDTH or Y0>=FB_HEIGHT.
  - Internal arithmetic is 17 bits wide, so X0+W cannot wrap.
- State machine IDLE -> SETUP -> WRITE -> (SETUP | FINISH) -> IDLE:
  - IDLE: a start write at cycle N, when not busy, latches the clipped bounds. busy=1 from N+1. Start while busy is ignored.
  - An empty rectangle goes IDLE -> FINISH: no mem_req is issued and done=1 at N+2.
  - SETUP (1 cycle):
    - row address = FB_BASE_WORD + y*(FB_WIDTH/4) + (X0>>2). Implement as an accumulator adding FB_WIDTH/4 per row; no multiplier.
    - Word counter runs from X0>>2 to xe>>2.
  - WRITE:
    - mem_req=1, mem_wdata={4{COLOR}}.
    - mem_wmask lane i = 1 iff pixel (word*4+i) lies in [X0, xe].
    - addr/data/mask are held stable while mem_ack=0.
    - On mem_ack, advance to the next word in the same cycle, so mem_req stays high back-to-back.
    - After the last word of a row: go to SETUP if y<ye, else FINISH. mem_req=0 in SETUP.
  - FINISH (1 cycle): done=1, busy=0 on exit to IDLE.
- First mem_req is asserted at N+2.
- done is sticky. It clears on a CTRL write with bit1=1, or on a new start. If both bits are written together: clear, then start.
- mem_ack while mem_req=0 is ignored.

Decomposition:
- Package soc_fb_fill_pkg holds:
  - the register index localparams (REG_X0 .. REG_CTRL);
  - the state enum fill_state_t {IDLE, SETUP, WRITE, FINISH};
  - the CTRL bit positions.
- One sub-module, soc_fb_fill_mask: combinational lane-mask generator (word index, xs, xe -> 4-bit mask). Kept separate for unit testing.

Test Plan:
- FB_WIDTH=640. X0=1, Y0=0, W=6, H=1, COLOR=0xAB, start -> exactly 2 writes:
  - addr 0, data 0xABABABAB, mask 1110;
  - addr 1, mask 0111;
  - then done=1, busy=0.
- X0=4, Y0=2, W=4, H=2, COLOR=0x3C, mem_ack always 1 -> writes to addr 321 then 481, both mask 1111, data 0x3C3C3C3C. The SETUP gap (mem_req=0 for 1 cycle) appears between rows.
- Backpressure: same fill with mem_ack held 0 for 5 cycles on the first request -> mem_req, mem_addr, mem_wdata and mem_wmask are unchanged for all 5 cycles, and the count of accepted writes is unchanged.
- Boundary/clipping:
  - W=0 -> no mem_req, done=1 two cycles after start.
  - X0=638, W=10, Y0=479, H=5 -> single write, addr 479*160+159=76799, mask 1100.
- Start written while busy, plus register writes while busy -> ignored; the original fill completes with its original parameters.
- Reset mid-fill: res low during row 2 of an H=4 fill -> mem_req=0 in the same cycle, busy=0 and done=0. After release, a new start fills correctly.
